// File: rtl/ps2_key_decoder_pkg.sv
// Shared definitions for the PS/2 keyboard front end.
//   KEY_TABLE  : scancode for each key index 0..15
//   BRK_PREFIX : break prefix byte (0xF0)
//   EXT_PREFIX : extended prefix byte (0xE0)
//   key_evt_t  : one queued key event {code, is_release}
//   rx_state_t : frame receiver states
//   key_lookup : scancode -> {hit, index} over the first num_keys table entries
package ps2_pkg;

    localparam int MAX_KEYS = 16;

    localparam logic [7:0] BRK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX = 8'hE0;

    localparam logic [7:0] KEY_TABLE [0:MAX_KEYS-1] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
        8'h3B, 8'h4B, 8'h31, 8'h44, 8'h4D, 8'h2D, 8'h1B, 8'h35
    };

    // code is sized for the largest table; the top narrows it to CODE_W
    typedef struct packed {
        logic [3:0] code;
        logic       is_release;
    } key_evt_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } key_lookup_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // Entries at or above num_keys are treated as unmapped.
    function automatic key_lookup_t key_lookup(input logic [7:0] scancode,
                                               input int         num_keys);
        key_lookup_t r;
        r.hit = 1'b0;
        r.idx = '0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            if (!r.hit && (i < num_keys) && (KEY_TABLE[i] == scancode)) begin
                r.hit = 1'b1;
                r.idx = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Key event stream between the decoder FIFO and its consumer.
//   key_valid   : head entry present (master -> slave)
//   key_ready   : consumer takes the head entry (slave -> master)
//   key_code    : key index of the head entry
//   key_release : head entry is a break
interface ps2_key_decoder_if #(
    parameter int CODE_W = 4
);
    logic              key_valid;
    logic              key_ready;
    logic [CODE_W-1:0] key_code;
    logic              key_release;

    modport master (
        output key_valid,
        output key_code,
        output key_release,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_code,
        input  key_release,
        output key_ready
    );
endinterface

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 frame receiver: synchronises the raw pins, detects kbdclk falling
// edges, assembles 11-bit frames (start, 8 data LSB first, odd parity, stop)
// and aborts a stalled partial frame after TIMEOUT_CYC idle cycles.
//   clk, rst  : system clock, synchronous active-high reset
//   kbdclk    : raw PS/2 clock pin
//   kbddat    : raw PS/2 data pin
//   rx_byte   : last good byte (valid with byte_stb)
//   byte_stb  : one-cycle strobe per good byte
//   err       : one-cycle pulse on bad start/parity/stop or timeout
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbdclk,
    input  logic       kbddat,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       err
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [1:0]       kclk_sync_reg;
    logic [1:0]       kdat_sync_reg;
    logic             kclk_prev_reg;
    rx_state_t        state_reg,   state_next;
    logic [2:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       shift_reg,   shift_next;
    logic             par_err_reg, par_err_next;
    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic [7:0]       byte_reg,    byte_next;
    logic             stb_reg,     stb_next;
    logic             err_reg,     err_next;
    logic             fall;
    logic             sample;
    logic             timeout;

    // Synchronisers idle high so reset release never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            kclk_sync_reg <= 2'b11;
            kdat_sync_reg <= 2'b11;
            kclk_prev_reg <= 1'b1;
        end else begin
            kclk_sync_reg <= {kclk_sync_reg[0], kbdclk};
            kdat_sync_reg <= {kdat_sync_reg[0], kbddat};
            kclk_prev_reg <= kclk_sync_reg[1];
        end
    end

    assign fall    = kclk_prev_reg & ~kclk_sync_reg[1];
    assign sample  = kdat_sync_reg[1];
    assign timeout = (state_reg != ST_IDLE) && !fall && (tmo_cnt_reg == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            par_err_reg <= 1'b0;
            tmo_cnt_reg <= '0;
            byte_reg    <= '0;
            stb_reg     <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            par_err_reg <= par_err_next;
            tmo_cnt_reg <= tmo_cnt_next;
            byte_reg    <= byte_next;
            stb_reg     <= stb_next;
            err_reg     <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        par_err_next = par_err_reg;
        byte_next    = byte_reg;
        stb_next     = 1'b0;
        err_next     = 1'b0;

        // Idle counter only runs inside a frame and restarts on every edge.
        if (fall || (state_reg == ST_IDLE) || timeout) begin
            tmo_cnt_next = '0;
        end else begin
            tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
        end

        if (timeout) begin
            state_next = ST_IDLE;
            err_next   = 1'b1;
        end else if (fall) begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (!sample) begin
                        state_next   = ST_DATA;
                        bit_cnt_next = '0;
                        par_err_next = 1'b0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_next   = {sample, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    // Odd parity: data plus parity must hold an odd number of ones.
                    par_err_next = ~(^shift_reg ^ sample);
                    state_next   = ST_STOP;
                end
                ST_STOP: begin
                    if (!sample || par_err_reg) begin
                        err_next = 1'b1;
                    end else begin
                        byte_next = shift_reg;
                        stb_next  = 1'b1;
                    end
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign rx_byte  = byte_reg;
    assign byte_stb = stb_reg;
    assign err      = err_reg;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: frame receiver, make/break/extended prefix
// tracking, held-key bitmap with optional typematic filtering, and a small
// valid/ready event FIFO.
//   clk, rst   : system clock, synchronous active-high reset
//   kbdclk     : raw PS/2 clock pin
//   kbddat     : raw PS/2 data pin
//   evt        : event stream (key_valid/key_ready/key_code/key_release)
//   held       : bitmap of currently pressed keys
//   frame_err  : one-cycle pulse on a bad or timed-out frame
//   overflow   : one-cycle pulse when an event is dropped on a full FIFO
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int NUM_KEYS       = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPORT_RELEASE = 0,
    parameter int REPEAT_FILTER  = 1,
    parameter int TIMEOUT_CYC    = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    kbdclk,
    input  logic                    kbddat,
    ps2_key_decoder_if.master       evt,
    output logic [NUM_KEYS-1:0]     held,
    output logic                    frame_err,
    output logic                    overflow
);

    localparam int CODE_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    logic [7:0] rx_byte;
    logic       byte_stb;
    logic       rx_err;

    ps2_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .kbdclk   (kbdclk),
        .kbddat   (kbddat),
        .rx_byte  (rx_byte),
        .byte_stb (byte_stb),
        .err      (rx_err)
    );

    // ---------------- prefix layer and held bitmap ----------------
    key_lookup_t         lk;
    logic                mapped;
    logic [NUM_KEYS-1:0] key_sel;
    logic                was_held;

    logic                brk_reg,  brk_next;
    logic                ext_reg,  ext_next;
    logic [NUM_KEYS-1:0] held_reg, held_next;
    logic                push_reg, push_next;
    key_evt_t            evt_reg,  evt_next;

    assign lk     = key_lookup(rx_byte, NUM_KEYS);
    assign mapped = byte_stb && (rx_byte != BRK_PREFIX) && (rx_byte != EXT_PREFIX)
                    && !ext_reg && lk.hit;

    // One-hot select of the key addressed by the current final byte.
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key_sel
        assign key_sel[gi] = mapped && (lk.idx == 4'(gi));
    end

    assign was_held = |(held_reg & key_sel);

    always_comb begin
        brk_next  = brk_reg;
        ext_next  = ext_reg;
        held_next = held_reg;
        push_next = 1'b0;
        evt_next  = evt_reg;

        if (byte_stb) begin
            if (rx_byte == BRK_PREFIX) begin
                brk_next = 1'b1;
            end else if (rx_byte == EXT_PREFIX) begin
                ext_next = 1'b1;
            end else begin
                brk_next = 1'b0;
                ext_next = 1'b0;
                if (mapped) begin
                    evt_next = '{code: lk.idx, is_release: brk_reg};
                    if (brk_reg) begin
                        held_next = held_reg & ~key_sel;
                        push_next = (REPORT_RELEASE != 0);
                    end else begin
                        held_next = held_reg | key_sel;
                        push_next = !((REPEAT_FILTER != 0) && was_held);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            brk_reg  <= 1'b0;
            ext_reg  <= 1'b0;
            held_reg <= '0;
            push_reg <= 1'b0;
            evt_reg  <= '0;
        end else begin
            brk_reg  <= brk_next;
            ext_reg  <= ext_next;
            held_reg <= held_next;
            push_reg <= push_next;
            evt_reg  <= evt_next;
        end
    end

    // ---------------- event FIFO ----------------
    key_evt_t         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             overflow_reg;
    logic             fifo_full;
    logic             fifo_pop;
    logic             fifo_wr;
    logic             fifo_valid;
    key_evt_t         head;

    assign fifo_valid = (count_reg != '0);
    assign fifo_full  = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_pop   = fifo_valid && evt.key_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign fifo_wr    = push_reg && (!fifo_full || fifo_pop);

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_reg] <= evt_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg    <= count_reg + (PTR_W+1)'(fifo_wr) - (PTR_W+1)'(fifo_pop);
            overflow_reg <= push_reg && fifo_full && !fifo_pop;
        end
    end

    // Head is forced to zero when empty so outputs are clean out of reset.
    assign head            = fifo_mem[rd_ptr_reg];
    assign evt.key_valid   = fifo_valid;
    assign evt.key_code    = fifo_valid ? head.code[CODE_W-1:0] : '0;
    assign evt.key_release = fifo_valid && head.is_release;

    assign held      = held_reg;
    assign frame_err = rx_err;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

    localparam int HALF = 10;     // clk cycles per PS/2 clock half period
    localparam int TMO  = 300;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic kbdclk = 1'b1;
    logic kbddat = 1'b1;

    always #5 clk = ~clk;

    ps2_key_decoder_if #(.CODE_W(4)) if_a ();
    ps2_key_decoder_if #(.CODE_W(4)) if_b ();

    logic [15:0] held_a, held_b;
    logic        ferr_a, ferr_b, ovf_a, ovf_b;

    // dut_a reports releases, dut_b reports makes only; both filter repeats.
    ps2_key_decoder #(
        .NUM_KEYS(16), .FIFO_DEPTH(4), .REPORT_RELEASE(1),
        .REPEAT_FILTER(1), .TIMEOUT_CYC(TMO)
    ) dut_a (
        .clk(clk), .rst(rst), .kbdclk(kbdclk), .kbddat(kbddat),
        .evt(if_a), .held(held_a), .frame_err(ferr_a), .overflow(ovf_a)
    );

    ps2_key_decoder #(
        .NUM_KEYS(16), .FIFO_DEPTH(4), .REPORT_RELEASE(0),
        .REPEAT_FILTER(1), .TIMEOUT_CYC(TMO)
    ) dut_b (
        .clk(clk), .rst(rst), .kbdclk(kbdclk), .kbddat(kbddat),
        .evt(if_b), .held(held_b), .frame_err(ferr_b), .overflow(ovf_b)
    );

    logic [7:0] key_tab [16] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
        8'h3B, 8'h4B, 8'h31, 8'h44, 8'h4D, 8'h2D, 8'h1B, 8'h35
    };

    // ---------------- monitor: observations only ----------------
    logic [4:0] obs_a[$];
    logic [4:0] obs_b[$];
    int err_a_cnt = 0, err_b_cnt = 0, ovf_a_cnt = 0, ovf_b_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (if_a.key_valid && if_a.key_ready) obs_a.push_back({if_a.key_code, if_a.key_release});
            if (if_b.key_valid && if_b.key_ready) obs_b.push_back({if_b.key_code, if_b.key_release});
            if (ferr_a) err_a_cnt++;
            if (ferr_b) err_b_cnt++;
            if (ovf_a)  ovf_a_cnt++;
            if (ovf_b)  ovf_b_cnt++;
        end
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int rd_a = 0, rd_b = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  b;
        int          corrupt;   // 0 good, 1 bad parity, 2 bad stop
        int          err;
        int          ev_a;
        int          ev_b;
        logic [4:0]  evt;       // {code, release}
        logic [15:0] held;
    } vec_t;

    // nbits < 11 sends only the leading bits of a frame
    task automatic send_frame(input logic [7:0] b, input int corrupt, input int nbits);
        logic [10:0] bits;
        logic        par;
        logic        stop;
        par  = ~^b;
        if (corrupt == 1) par = ~par;
        stop = (corrupt == 2) ? 1'b0 : 1'b1;
        bits = {stop, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            kbddat = bits[i];
            repeat (HALF) @(posedge clk);
            kbdclk = 1'b0;
            repeat (HALF) @(posedge clk);
            kbdclk = 1'b1;
        end
        repeat (HALF) @(posedge clk);
        kbddat = 1'b1;
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        int ea0, eb0;
        ea0 = err_a_cnt;
        eb0 = err_b_cnt;
        send_frame(v.b, v.corrupt, 11);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, " err_a"}, err_a_cnt - ea0, v.err);
        chk({tag, " err_b"}, err_b_cnt - eb0, v.err);
        chk({tag, " nev_a"}, obs_a.size() - rd_a, v.ev_a);
        if (v.ev_a == 1 && obs_a.size() > rd_a) chk({tag, " evt_a"}, obs_a[rd_a], v.evt);
        chk({tag, " nev_b"}, obs_b.size() - rd_b, v.ev_b);
        if (v.ev_b == 1 && obs_b.size() > rd_b) chk({tag, " evt_b"}, obs_b[rd_b], v.evt);
        rd_a = obs_a.size();
        rd_b = obs_b.size();
        chk({tag, " held_a"}, held_a, v.held);
        chk({tag, " held_b"}, held_b, v.held);
        $display("frame %s byte=%02h corrupt=%0d held_a=%04h", tag, v.b, v.corrupt, held_a);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, " valid_a"}, if_a.key_valid, 0);
        chk({tag, " code_a"}, if_a.key_code, 0);
        chk({tag, " rel_a"}, if_a.key_release, 0);
        chk({tag, " held_a"}, held_a, 0);
        chk({tag, " ferr_a"}, ferr_a, 0);
        chk({tag, " ovf_a"}, ovf_a, 0);
        chk({tag, " valid_b"}, if_b.key_valid, 0);
        chk({tag, " held_b"}, held_b, 0);
        chk({tag, " ferr_b"}, ferr_b, 0);
        chk({tag, " ovf_b"}, ovf_b, 0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        vec_t        tbl [22];
        vec_t        v;
        logic [7:0]  seq5 [5];
        logic        m_brk, m_ext;
        logic [15:0] m_held;
        logic [7:0]  b;
        int          r, idx, corrupt, e0, o0a, o0b;

        tbl[0]  = '{8'h1C, 0, 0, 1, 1, 5'h00, 16'h0001};
        tbl[1]  = '{8'hF0, 0, 0, 0, 0, 5'h00, 16'h0001};
        tbl[2]  = '{8'h1C, 0, 0, 1, 0, 5'h01, 16'h0000};
        tbl[3]  = '{8'h32, 0, 0, 1, 1, 5'h02, 16'h0002};
        tbl[4]  = '{8'h32, 0, 0, 0, 0, 5'h00, 16'h0002};
        tbl[5]  = '{8'h32, 0, 0, 0, 0, 5'h00, 16'h0002};
        tbl[6]  = '{8'hF0, 0, 0, 0, 0, 5'h00, 16'h0002};
        tbl[7]  = '{8'h32, 0, 0, 1, 0, 5'h03, 16'h0000};
        tbl[8]  = '{8'h21, 1, 1, 0, 0, 5'h00, 16'h0000};
        tbl[9]  = '{8'h21, 0, 0, 1, 1, 5'h04, 16'h0004};
        tbl[10] = '{8'hF0, 0, 0, 0, 0, 5'h00, 16'h0004};
        tbl[11] = '{8'h21, 0, 0, 1, 0, 5'h05, 16'h0000};
        tbl[12] = '{8'hE0, 0, 0, 0, 0, 5'h00, 16'h0000};
        tbl[13] = '{8'h1C, 0, 0, 0, 0, 5'h00, 16'h0000};
        tbl[14] = '{8'h5A, 0, 0, 0, 0, 5'h00, 16'h0000};
        tbl[15] = '{8'hE0, 0, 0, 0, 0, 5'h00, 16'h0000};
        tbl[16] = '{8'hF0, 0, 0, 0, 0, 5'h00, 16'h0000};
        tbl[17] = '{8'h1C, 0, 0, 0, 0, 5'h00, 16'h0000};
        tbl[18] = '{8'h1C, 0, 0, 1, 1, 5'h00, 16'h0001};
        tbl[19] = '{8'h23, 2, 1, 0, 0, 5'h00, 16'h0001};
        tbl[20] = '{8'hF0, 0, 0, 0, 0, 5'h00, 16'h0001};
        tbl[21] = '{8'h1C, 0, 0, 1, 0, 5'h01, 16'h0000};

        if_a.key_ready = 1'b1;
        if_b.key_ready = 1'b1;

        // reset state
        repeat (5) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        repeat (5) @(posedge clk);

        // table-driven directed frames
        for (int i = 0; i < 22; i++) begin
            apply_vec($sformatf("tbl%0d", i), tbl[i]);
        end

        // FIFO fill and overflow with the consumer stalled
        seq5 = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
        if_a.key_ready = 1'b0;
        if_b.key_ready = 1'b0;
        o0a = ovf_a_cnt;
        o0b = ovf_b_cnt;
        for (int i = 0; i < 5; i++) begin
            send_frame(seq5[i], 0, 11);
            repeat (4) @(posedge clk);
            #1;
            if (i == 3) begin
                chk("fifo4 valid_a", if_a.key_valid, 1);
                chk("fifo4 code_a", if_a.key_code, 0);
                chk("fifo4 ovf_a", ovf_a_cnt - o0a, 0);
            end
            if (i == 4) begin
                chk("fifo5 ovf_a", ovf_a_cnt - o0a, 1);
                chk("fifo5 ovf_b", ovf_b_cnt - o0b, 1);
                chk("fifo5 code_a", if_a.key_code, 0);
                chk("fifo5 rel_a", if_a.key_release, 0);
                chk("fifo5 held_a", held_a, 16'h001F);
            end
            $display("stall push %0d byte=%02h ovf_a=%0d", i, seq5[i], ovf_a_cnt - o0a);
        end
        if_a.key_ready = 1'b1;
        if_b.key_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("drain nev_a", obs_a.size() - rd_a, 4);
        chk("drain nev_b", obs_b.size() - rd_b, 4);
        for (int k = 0; k < 4; k++) begin
            if (obs_a.size() > rd_a + k) chk($sformatf("drain a%0d", k), obs_a[rd_a + k], k * 2);
            if (obs_b.size() > rd_b + k) chk($sformatf("drain b%0d", k), obs_b[rd_b + k], k * 2);
        end
        rd_a = obs_a.size();
        rd_b = obs_b.size();
        chk("drain valid_a", if_a.key_valid, 0);
        $display("drain done valid_a=%0d", if_a.key_valid);

        // timeout of a partial frame
        e0 = err_a_cnt;
        send_frame(8'h35, 0, 4);
        repeat (TMO - 40) @(posedge clk);
        #1;
        chk("tmo early err_a", err_a_cnt - e0, 0);
        repeat (80) @(posedge clk);
        #1;
        chk("tmo err_a", err_a_cnt - e0, 1);
        $display("timeout err_a=%0d", err_a_cnt - e0);
        apply_vec("tmo_next", '{8'h35, 0, 0, 1, 1, 5'h1E, 16'h801F});

        // prefixes and an unmapped code, then reset mid-frame
        apply_vec("rst_e0", '{8'hE0, 0, 0, 0, 0, 5'h00, 16'h801F});
        apply_vec("rst_1c", '{8'h1C, 0, 0, 0, 0, 5'h00, 16'h801F});
        apply_vec("rst_5a", '{8'h5A, 0, 0, 0, 0, 5'h00, 16'h801F});
        send_frame(8'h1C, 0, 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero_outputs("midrst");
        kbdclk = 1'b1;
        kbddat = 1'b1;
        repeat (3) @(posedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        $display("reset mid-frame applied");

        // randomized frames against a behavioural model
        m_brk  = 1'b0;
        m_ext  = 1'b0;
        m_held = '0;
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5)       b = key_tab[$urandom_range(0, 15)];
            else if (r < 7)  b = 8'hF0;
            else if (r == 7) b = 8'hE0;
            else             b = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 11);
            corrupt = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            v = '{b, corrupt, (corrupt != 0) ? 1 : 0, 0, 0, 5'h00, 16'h0000};
            if (corrupt == 0) begin
                if (b == 8'hF0) begin
                    m_brk = 1'b1;
                end else if (b == 8'hE0) begin
                    m_ext = 1'b1;
                end else begin
                    idx = -1;
                    for (int k = 0; k < 16; k++) if (idx < 0 && key_tab[k] == b) idx = k;
                    if (!m_ext && idx >= 0) begin
                        if (m_brk) begin
                            v.ev_a = 1;
                            v.evt  = {4'(idx), 1'b1};
                            m_held[idx] = 1'b0;
                        end else begin
                            if (!m_held[idx]) begin
                                v.ev_a = 1;
                                v.ev_b = 1;
                            end
                            v.evt = {4'(idx), 1'b0};
                            m_held[idx] = 1'b1;
                        end
                    end
                    m_brk = 1'b0;
                    m_ext = 1'b0;
                end
            end
            v.held = m_held;
            apply_vec($sformatf("rnd%0d", n), v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised PS/2 keyboard front end that supersedes the free-running scancode-to-letter lookup. It receives and validates raw PS/2 frames in the system clock domain, tracks make/break (0xF0) and extended (0xE0) prefixes, and filters typematic repeats. Decoded key events are buffered in a small valid/ready FIFO for the game/display logic. It sits directly behind the board's PS/2 pins, and its event stream replaces the old level-held letter output.

## Interface
- NUM_KEYS, 16: number of active key-table entries (1..16); entries at or above NUM_KEYS are treated as unmapped
- FIFO_DEPTH, 4: event FIFO depth; power of two, at least 2
- REPORT_RELEASE, 0: 0 = push events on make only; 1 = also push events on break
- REPEAT_FILTER, 1: 1 = suppress make codes for keys already held
- TIMEOUT_CYC, 100000: clk cycles without a kbdclk falling edge before a partial frame is aborted
- clk  in  1  system clock; one clock only
- rst  in  1  reset, synchronous, active-high
- kbdclk  in  1  raw PS/2 clock (asynchronous)
- kbddat  in  1  raw PS/2 data (asynchronous)
- key_valid  out  1  FIFO head holds an event
- key_ready  in  1  consumer accepts the head event when key_valid && key_ready
- key_code  out  CODE_W  key index 0..NUM_KEYS-1; CODE_W = $clog2(NUM_KEYS), minimum 1
- key_release  out  1  head event is a break
- held  out  NUM_KEYS  bitmap of currently pressed keys
- frame_err  out  1  one-cycle pulse on bad start, parity, or stop bit, or on timeout
- overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full

## Operation
- kbdclk and kbddat each pass through a 2-flop synchroniser. A falling edge is the synced kbdclk going 1 to 0; kbddat is sampled on that edge.
- Frame FSM states are IDLE, DATA, PARITY, STOP.
- IDLE: the FSM moves to DATA when the sampled bit is 0. If the sampled bit is 1, it pulses frame_err and stays in IDLE.
- DATA: 8 bits are shifted in LSB first. The FSM then moves to PARITY.
- PARITY: the total count of ones across data and parity must be odd. On a mismatch, a flag is set and the frame finishes.
- STOP: the stop bit must be 1. On a bad stop bit or a set parity flag, frame_err pulses and the byte is discarded. Otherwise the byte is delivered to the prefix layer. The FSM returns to IDLE in either case.
- Timeout: in any state other than IDLE, an idle counter that reaches TIMEOUT_CYC forces the FSM to IDLE and pulses frame_err. The counter clears on every falling edge.
- Prefix layer, byte 0xF0: sets brk.
- Prefix layer, byte 0xE0: sets ext.
- Prefix layer, any other byte: this is the final byte. If ext is set, the byte is discarded. Otherwise it is looked up in KEY_TABLE. brk and ext clear after every final byte.
- Mapped make: sets held[i]. When REPEAT_FILTER=1 and held[i] was already set, no event is produced. Otherwise the event {i, release=0} is pushed.
- Mapped break: clears held[i]. The event {i, release=1} is pushed only when REPORT_RELEASE=1.
- Unmapped codes: no event and no change to held.
- FIFO: a push while full is dropped and pulses overflow. A push and a pop in the same cycle while full are both accepted (count unchanged). A pop while empty is ignored.
- Reset clears all of the following: FSM to IDLE, bit counter, shift register, brk, ext, held, FIFO pointers, and the timeout counter. All outputs go to 0. A frame in progress at reset is discarded.

## Timing
- Let cycle T be the clk edge at which the synced kbdclk falling edge of the stop bit is detected. The byte is classified at T+1, the FIFO is written at T+2, and key_valid=1 at T+2 when the FIFO was empty.
- The raw pin to synced edge delay is 2 cycles. The worst-case end-to-end latency is therefore 4 clk cycles plus synchroniser phase.
- held updates at T+1, independent of FIFO state. A dropped event still updates held.
- key_code and key_release are stable while key_valid && !key_ready. The next entry appears on the cycle after a pop.
- frame_err and overflow are registered and high for exactly one cycle.
- The minimum supported clk is 8x the PS/2 clock (50 MHz nominal against 10-16.7 kHz).

## Structure
- Package ps2_pkg contains the following:
  - KEY_TABLE[0:15] scancodes: 1C, 32, 21, 23, 24, 2B, 34, 33, 3B, 4B, 31, 44, 4D, 2D, 1B, 35
  - constants BRK_PREFIX=8'hF0 and EXT_PREFIX=8'hE0
  - the event struct {code, release}
- Sub-module ps2_rx contains the synchroniser, edge detect, frame FSM, and timeout, and outputs byte plus byte_stb plus err.
- The prefix layer, the held bitmap, and the FIFO live in ps2_key_decoder.

## Test plan
- Frame 0x1C, then F0 1C, with REPORT_RELEASE=1: two events are pushed, {0,0} then {0,1}. held[0] goes 1 then 0.
- Make 0x32 sent 3 times, then F0 32, with REPEAT_FILTER=1 and REPORT_RELEASE=0: one event {1,0} is pushed. held[1]=1 after the makes and 0 after the break.
- Frame 0x21 with even parity: frame_err pulses once, no event is pushed, held is unchanged. A following good 0x21 yields {2,0}.
- key_ready=0 while 5 distinct makes are sent (FIFO_DEPTH=4): the fourth push fills the FIFO, the fifth pulses overflow, and pops return codes in order.
- 4 bits of a frame, then silence for TIMEOUT_CYC cycles: frame_err pulses and the FSM returns to IDLE. The next full frame 0x35 decodes to {15,0}.
- Sequence E0 1C, then an unmapped 0x5A, then rst asserted mid-frame: no events are pushed, and all outputs are 0 in the cycle after rst.
